// File: rtl/multicycle_control.sv
// multicycle_control: phase sequencer for the multicycle MIPS datapath.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction, decodes the
// per-phase enables/selects from the current state, and counts retired
// instructions (one per PC load).
// Optional build macro MC_ILLEGAL_TRAP_EN: when defined, opfunc codes 13-15
// trap to HALT instead of retiring as a NOP.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       opfunc,
  input  logic             halt,
  input  logic             zero,
  input  logic             ihit,
  input  logic             dhit,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             irWEN,
  output logic             mdrWEN,
  output logic             regWEN,
  output logic             pcWEN,
  output logic [1:0]       pcsrc,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_JUNK   = 4'd0;
  localparam logic [3:0] OP_JR     = 4'd1;
  localparam logic [3:0] OP_SL     = 4'd2;
  localparam logic [3:0] OP_BEQ    = 4'd3;
  localparam logic [3:0] OP_BNE    = 4'd4;
  localparam logic [3:0] OP_SW     = 4'd5;
  localparam logic [3:0] OP_LW     = 4'd6;
  localparam logic [3:0] OP_LUI    = 4'd7;
  localparam logic [3:0] OP_J      = 4'd8;
  localparam logic [3:0] OP_JAL    = 4'd9;
  localparam logic [3:0] OP_OTHERR = 4'd10;
  localparam logic [3:0] OP_OTHERI = 4'd11;
  localparam logic [3:0] OP_ERRMIN = 4'd13;

  localparam logic [1:0] PC_NPC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_JREG   = 2'd3;

  localparam logic [1:0] RD_RD  = 2'd0;
  localparam logic [1:0] RD_RT  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  localparam logic [1:0] MR_ALUO  = 2'd0;
  localparam logic [1:0] MR_DLOAD = 2'd1;
  localparam logic [1:0] MR_PORTB = 2'd2;
  localparam logic [1:0] MR_NPC   = 2'd3;

  logic [2:0] state_next;
  logic       illegal_set;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state and per-phase enable/select decode.
  always_comb begin
    state_next  = state;
    iREN        = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    irWEN       = 1'b0;
    mdrWEN      = 1'b0;
    regWEN      = 1'b0;
    pcWEN       = 1'b0;
    pcsrc       = PC_NPC;
    regdst      = RD_RD;
    memtoreg    = MR_ALUO;
    illegal_set = 1'b0;

    case (state)
      S_FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          irWEN      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (opfunc)
          OP_BEQ: begin
            pcWEN      = 1'b1;
            pcsrc      = zero ? PC_BRANCH : PC_NPC;
            state_next = S_FETCH;
          end
          OP_BNE: begin
            pcWEN      = 1'b1;
            pcsrc      = zero ? PC_NPC : PC_BRANCH;
            state_next = S_FETCH;
          end
          OP_J: begin
            pcWEN      = 1'b1;
            pcsrc      = PC_JUMP;
            state_next = S_FETCH;
          end
          OP_JR: begin
            pcWEN      = 1'b1;
            pcsrc      = PC_JREG;
            state_next = S_FETCH;
          end
          OP_SW, OP_LW: state_next = S_MEM;
          OP_SL, OP_LUI, OP_JAL, OP_OTHERR, OP_OTHERI: state_next = S_WB;
          default: begin
            // JUNK / OTHERJ / error codes retire as a NOP unless trapping
            illegal_set = (opfunc >= OP_ERRMIN);
`ifdef MC_ILLEGAL_TRAP_EN
            if (illegal_set) begin
              state_next = S_HALT;
            end else begin
              pcWEN      = 1'b1;
              state_next = S_FETCH;
            end
`else
            pcWEN      = 1'b1;
            state_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        if (opfunc == OP_LW) begin
          dREN = 1'b1;
          if (dhit) begin
            mdrWEN     = 1'b1;
            state_next = S_WB;
          end
        end else begin
          dWEN = 1'b1;
          if (dhit) begin
            pcWEN      = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_WB: begin
        regWEN     = 1'b1;
        pcWEN      = 1'b1;
        state_next = S_FETCH;
        case (opfunc)
          OP_JAL: begin
            pcsrc    = PC_JUMP;
            regdst   = RD_R31;
            memtoreg = MR_NPC;
          end
          OP_OTHERI: begin
            regdst   = RD_RT;
            memtoreg = MR_ALUO;
          end
          OP_LUI: begin
            regdst   = RD_RT;
            memtoreg = MR_PORTB;
          end
          OP_LW: begin
            regdst   = RD_RT;
            memtoreg = MR_DLOAD;
          end
          default: begin
            regdst   = RD_RD;
            memtoreg = MR_ALUO;
          end
        endcase
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase

    // Reset dominates: nothing is requested or written while it is held.
    if (RST) begin
      iREN        = 1'b0;
      dREN        = 1'b0;
      dWEN        = 1'b0;
      irWEN       = 1'b0;
      mdrWEN      = 1'b0;
      regWEN      = 1'b0;
      pcWEN       = 1'b0;
      pcsrc       = PC_NPC;
      regdst      = RD_RD;
      memtoreg    = MR_ALUO;
      illegal_set = 1'b0;
    end
  end

  // Sticky halt flag, raised together with entry into HALT.
  always_ff @(posedge CLK) begin
    if (RST)                        halted <= 1'b0;
    else if (state_next == S_HALT)  halted <= 1'b1;
  end

  // Sticky illegal-opcode flag.
  always_ff @(posedge CLK) begin
    if (RST)              illegal <= 1'b0;
    else if (illegal_set) illegal <= 1'b1;
  end

  // Retired-instruction counter; wraps naturally at its width.
  always_ff @(posedge CLK) begin
    if (RST)        instr_count <= '0;
    else if (pcWEN) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios followed by
// randomized instruction streams, all checked every cycle against an
// instruction-level reference model.
module tb_multicycle_control;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MOD = 16;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic [3:0]       opfunc;
  logic             halt, zero, ihit, dhit;
  logic             iREN, dREN, dWEN, irWEN, mdrWEN, regWEN, pcWEN;
  logic [1:0]       pcsrc, regdst, memtoreg;
  logic             halted, illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .opfunc(opfunc), .halt(halt), .zero(zero),
    .ihit(ihit), .dhit(dhit), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .irWEN(irWEN), .mdrWEN(mdrWEN), .regWEN(regWEN), .pcWEN(pcWEN),
    .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg), .halted(halted),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: phase of the current instruction (numbered as the
  // debug state output), retired count and sticky flags.
  int m_phase   = 0;
  int m_cnt     = 0;
  bit m_halted  = 1'b0;
  bit m_illegal = 1'b0;
  bit m_valid   = 1'b0;

  int t_dren = 0, t_pcwen = 0, t_iren = 0;
  int last_pcsrc = -1, last_regdst = -1, last_memtoreg = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit is_wb_op(input int op);
    return (op == 2) || (op == 7) || (op == 9) || (op == 10) || (op == 11);
  endfunction

  function automatic bit is_mem_op(input int op);
    return (op == 5) || (op == 6);
  endfunction

  // One clock: drive inputs, check every output against the model, advance.
  task automatic cyc(input bit r, input int op, input bit h, input bit z,
                     input bit ih, input bit dh);
    int e_iren, e_dren, e_dwen, e_irwen, e_mdrwen, e_regwen, e_pcwen;
    int e_pcsrc, e_regdst, e_memtoreg;
    bit taken;
    @(negedge CLK);
    RST = r; opfunc = 4'(op); halt = h; zero = z; ihit = ih; dhit = dh;
    #1;
    if (m_valid) begin
      chk("state", int'(state), m_phase);
      chk("halted", int'(halted), int'(m_halted));
      chk("illegal", int'(illegal), int'(m_illegal));
      chk("instr_count", int'(instr_count), m_cnt);
    end
    e_iren = 0; e_dren = 0; e_dwen = 0; e_irwen = 0; e_mdrwen = 0;
    e_regwen = 0; e_pcwen = 0; e_pcsrc = 0; e_regdst = 0; e_memtoreg = 0;
    case (m_phase)
      0: begin e_iren = 1; e_irwen = int'(ih); end
      2: begin
        if (op == 3 || op == 4) begin
          taken = (op == 3) ? z : !z;
          e_pcwen = 1; e_pcsrc = taken ? 1 : 0;
        end else if (op == 8) begin
          e_pcwen = 1; e_pcsrc = 2;
        end else if (op == 1) begin
          e_pcwen = 1; e_pcsrc = 3;
        end else if (!is_mem_op(op) && !is_wb_op(op) && !(TRAP && op >= 13)) begin
          e_pcwen = 1;
        end
      end
      3: begin
        if (op == 6) begin e_dren = 1; e_mdrwen = int'(dh); end
        if (op == 5) begin e_dwen = 1; e_pcwen = int'(dh); end
      end
      4: begin
        e_regwen = 1; e_pcwen = 1; e_pcsrc = (op == 9) ? 2 : 0;
        case (op)
          10, 2:   begin e_regdst = 0; e_memtoreg = 0; end
          11:      begin e_regdst = 1; e_memtoreg = 0; end
          7:       begin e_regdst = 1; e_memtoreg = 2; end
          6:       begin e_regdst = 1; e_memtoreg = 1; end
          9:       begin e_regdst = 2; e_memtoreg = 3; end
          default: begin e_regdst = 0; e_memtoreg = 0; end
        endcase
      end
      default: ;
    endcase
    if (!r && m_valid) begin
      chk("iREN", int'(iREN), e_iren);
      chk("dREN", int'(dREN), e_dren);
      chk("dWEN", int'(dWEN), e_dwen);
      chk("irWEN", int'(irWEN), e_irwen);
      chk("mdrWEN", int'(mdrWEN), e_mdrwen);
      chk("regWEN", int'(regWEN), e_regwen);
      chk("pcWEN", int'(pcWEN), e_pcwen);
      chk("pcsrc", int'(pcsrc), e_pcsrc);
      chk("regdst", int'(regdst), e_regdst);
      chk("memtoreg", int'(memtoreg), e_memtoreg);
    end
    if (dREN === 1'b1) t_dren++;
    if (iREN === 1'b1) t_iren++;
    if (pcWEN === 1'b1) begin t_pcwen++; last_pcsrc = int'(pcsrc); end
    if (regWEN === 1'b1) begin last_regdst = int'(regdst); last_memtoreg = int'(memtoreg); end
    @(posedge CLK);
    if (r) begin
      m_phase = 0; m_cnt = 0; m_halted = 1'b0; m_illegal = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (e_pcwen != 0) m_cnt = (m_cnt + 1) % CNT_MOD;
      case (m_phase)
        0: if (ih) m_phase = 1;
        1: if (h) begin m_phase = 5; m_halted = 1'b1; end else m_phase = 2;
        2: begin
          if (op >= 13) m_illegal = 1'b1;
          if (is_mem_op(op))           m_phase = 3;
          else if (is_wb_op(op))       m_phase = 4;
          else if (TRAP && op >= 13) begin m_phase = 5; m_halted = 1'b1; end
          else                         m_phase = 0;
        end
        3: if (dh) m_phase = (op == 6) ? 4 : 0;
        4: m_phase = 0;
        default: ;
      endcase
    end
  endtask

  task automatic clear_tally();
    t_dren = 0; t_pcwen = 0; t_iren = 0;
    last_pcsrc = -1; last_regdst = -1; last_memtoreg = -1;
  endtask

  initial begin
    int op_r;
    bit r_r;
    RST = 1'b1; opfunc = 4'd10; halt = 1'b0; zero = 1'b0; ihit = 1'b1; dhit = 1'b0;

    // Reset, then a stream of R-type ALU ops
    cyc(1, 10, 0, 0, 1, 0);
    cyc(1, 10, 0, 0, 1, 0);
    clear_tally();
    for (int i = 0; i < 12; i++) cyc(0, 10, 0, 0, 1, 0);
    #1;
    chk("alu_count", int'(instr_count), 3);
    chk("model_alu_count", m_cnt, 3);
    chk("alu_pcwen", t_pcwen, 3);
    chk("alu_state", int'(state), 0);

    // LW with three data wait cycles
    clear_tally();
    for (int i = 0; i < 8; i++) cyc(0, 6, 0, 0, 1, (i == 6));
    #1;
    chk("lw_dren_cycles", t_dren, 4);
    chk("lw_pcwen", t_pcwen, 1);
    chk("lw_regdst", last_regdst, 1);
    chk("lw_memtoreg", last_memtoreg, 1);
    chk("lw_state", int'(state), 0);

    // Branches
    clear_tally();
    for (int i = 0; i < 3; i++) cyc(0, 3, 0, 1, 1, 0);
    chk("beq_taken_pcsrc", last_pcsrc, 1);
    for (int i = 0; i < 3; i++) cyc(0, 3, 0, 0, 1, 0);
    chk("beq_nt_pcsrc", last_pcsrc, 0);
    for (int i = 0; i < 3; i++) cyc(0, 4, 0, 0, 1, 0);
    chk("bne_taken_pcsrc", last_pcsrc, 1);
    chk("branch_pcwen", t_pcwen, 3);

    // JAL
    clear_tally();
    for (int i = 0; i < 4; i++) cyc(0, 9, 0, 0, 1, 0);
    chk("jal_regdst", last_regdst, 2);
    chk("jal_memtoreg", last_memtoreg, 3);
    chk("jal_pcsrc", last_pcsrc, 2);

    // HALT is absorbing until reset
    cyc(0, 10, 0, 0, 1, 0);
    cyc(0, 10, 1, 0, 1, 0);
    clear_tally();
    for (int i = 0; i < 6; i++) cyc(0, 10, (i % 3 == 0), 0, (i % 2 == 0), 0);
    #1;
    chk("halt_iren", t_iren, 0);
    chk("halt_state", int'(state), 5);
    chk("halt_flag", int'(halted), 1);
    cyc(1, 10, 0, 0, 0, 0);
    #1;
    chk("halt_rst_state", int'(state), 0);
    chk("halt_rst_flag", int'(halted), 0);

    // Reset while a store is waiting in MEM
    for (int i = 0; i < 4; i++) cyc(0, 5, 0, 0, 1, 0);
    cyc(1, 5, 0, 0, 1, 1);
    cyc(0, 5, 0, 0, 0, 0);
    #1;
    chk("rstmem_count", int'(instr_count), 0);
    chk("rstmem_state", int'(state), 0);

    // 16 NOPs wrap the 4-bit counter
    clear_tally();
    for (int i = 0; i < 48; i++) cyc(0, 0, 0, 0, 1, 0);
    #1;
    chk("wrap_pcwen", t_pcwen, 16);
    chk("wrap_count", int'(instr_count), 0);

    // Illegal opcode
    for (int i = 0; i < 3; i++) cyc(0, 13, 0, 0, 1, 0);
    #1;
    chk("illegal_flag", int'(illegal), 1);
    chk("illegal_state", int'(state), TRAP ? 5 : 0);
    cyc(1, 0, 0, 0, 1, 0);

    // Randomized instruction streams
    op_r = 10;
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == 0) op_r = int'($urandom_range(0, 15));
      if (m_phase == 5) r_r = ($urandom_range(0, 3) == 0);
      else              r_r = ($urandom_range(0, 99) == 0);
      cyc(r_r, op_r, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) != 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing FSM for the multicycle MIPS datapath: drives instruction fetch, decode, execute, memory and writeback phases.
- Consumes the already-classified opfunc_t code from the decoder and produces per-phase write enables, memory requests and mux selects using the team's regdst_t/memtoreg_t encodings.
- Sits between the decoder/ALU and the datapath registers (PC, IR, MDR, register file); also owns the retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- opfunc  in  4  opfunc_t code of IR: 0 JUNK, 1 JR, 2 SL, 3 BEQ, 4 BNE, 5 SW, 6 LW, 7 LUI, 8 J, 9 JAL, 10 OTHERR, 11 OTHERI, 12 OTHERJ, 13-15 ERROR
- halt  in  1  IR holds HALT; sampled only in DECODE
- zero  in  1  ALU zero flag; sampled only in EXEC
- ihit  in  1  instruction memory done
- dhit  in  1  data memory done
- iREN  out  1  instruction read request
- dREN  out  1  data read request
- dWEN  out  1  data write request
- irWEN  out  1  IR load
- mdrWEN  out  1  MDR load
- regWEN  out  1  register file write
- pcWEN  out  1  PC load; exactly one pulse per retired instruction
- pcsrc  out  2  0 NPC, 1 BRANCH, 2 JUMP, 3 JREG
- regdst  out  2  regdst_t: 0 RD, 1 RT, 2 R31
- memtoreg  out  2  memtoreg_t: 0 ALUO, 1 DLOAD, 2 PORTB, 3 NPC
- halted  out  1  sticky halt indication
- illegal  out  1  sticky illegal-opcode flag
- state  out  3  debug state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (sync, RST=1 at edge): state=FETCH, instr_count=0, halted=0, illegal=0. All outputs are Moore/Mealy decodes of state and default 0, except iREN=1 in FETCH. RST dominates every other input. Mid-operation reset aborts the instruction with no pcWEN/regWEN.
- FETCH: iREN=1. ihit=1 -> irWEN=1, go DECODE. Else stay.
- DECODE: one cycle, no enables. halt=1 -> HALT. Else EXEC.
- EXEC:
  - BEQ: pcWEN=1, pcsrc=BRANCH if zero, else NPC, -> FETCH.
  - BNE: same, using !zero.
  - J: pcWEN=1, pcsrc=JUMP, -> FETCH.
  - JR: pcWEN=1, pcsrc=JREG, -> FETCH.
  - SW/LW -> MEM.
  - SL, LUI, JAL, OTHERR, OTHERI -> WB.
  - JUNK, OTHERJ, 13-15: pcWEN=1, pcsrc=NPC, no other writes (NOP), -> FETCH. Codes 13-15 also set illegal=1.
- MEM: dREN=1 for LW, dWEN=1 for SW, held until dhit.
  - dhit & SW: pcWEN=1, pcsrc=NPC, -> FETCH.
  - dhit & LW: mdrWEN=1, -> WB.
- WB: regWEN=1 and pcWEN=1.
  - pcsrc=JUMP for JAL, else NPC. Next state FETCH.
  - regdst/memtoreg selection:
    - OTHERR, SL: RD/ALUO
    - OTHERI: RT/ALUO
    - LUI: RT/PORTB
    - LW: RT/DLOAD
    - JAL: R31/NPC
  - regdst/memtoreg are 0 outside WB.
- HALT: absorbing until RST; halted=1; no requests or enables.
- opfunc is stable from DECODE through WB (IR only loads in FETCH). ihit outside FETCH and dhit outside MEM are ignored.
- instr_count increments by 1 on every pcWEN cycle and wraps from 2^CNT_W-1 to 0. HALT does not count.
- Latencies with zero-wait memory:
  - branch/jump/NOP: 3 cycles
  - ALU/LUI/JAL: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles
  - Each wait cycle on ihit/dhit adds 1.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: codes 13-15 in EXEC set illegal=1 and go to HALT (halted=1), with no pcWEN and no count increment.
- Undefined: codes 13-15 behave as NOP per EXEC rules; illegal is still set.

Test Plan:
- RST 2 cycles, then ihit=1 constant, opfunc=OTHERR -> states 0,1,2,4 repeating. regWEN & pcWEN pulse every 4th cycle with regdst=0, memtoreg=0. instr_count=3 after 12 cycles.
- opfunc=OLW, ihit=1, dhit delayed 3 cycles -> dREN high for 4 cycles, mdrWEN on the dhit cycle, then WB with regdst=1, memtoreg=1. Total 8 cycles, one pcWEN.
- opfunc=OBEQ: zero=1 -> pcsrc=1. zero=0 -> pcsrc=0. opfunc=OBNE with zero=0 -> pcsrc=1. Each takes 3 cycles and one pcWEN.
- opfunc=OJAL -> WB with regdst=2, memtoreg=3, pcsrc=2. halt=1 in DECODE -> state=5, halted=1, no further iREN even with ihit toggling; RST returns to FETCH with halted=0.
- RST asserted in MEM with dWEN active -> next cycle state=0, dWEN=0, no pcWEN, instr_count=0.
- CNT_W=4, 16 NOPs (opfunc=0) -> instr_count wraps to 0. opfunc=13 -> illegal=1; with MC_ILLEGAL_TRAP_EN state=5, without it NOP continues.
